// File: rtl/rsa256_uart_bridge.sv
// Avalon-MM master that polls a UART, gathers N, E and ciphertext for the RSA256 core,
// starts the core and streams the 31 low-order plaintext bytes back out through the UART.
module rsa256_uart_bridge #(
   parameter int unsigned RX_BASE     = 0,
   parameter int unsigned TX_BASE     = 1,
   parameter int unsigned STATUS_BASE = 2,
   parameter int unsigned RX_OK_BIT   = 7,
   parameter int unsigned TX_OK_BIT   = 6,
   parameter int unsigned IN_BYTES    = 32,
   parameter int unsigned OUT_BYTES   = 31
) (
   input  logic         i_clk,
   input  logic         i_rst,
   output logic [4:0]   avm_address,
   output logic         avm_read,
   input  logic [31:0]  avm_readdata,
   output logic         avm_write,
   output logic [31:0]  avm_writedata,
   input  logic         avm_waitrequest,
   output logic         o_core_start,
   output logic [255:0] o_core_a,
   output logic [255:0] o_core_e,
   output logic [255:0] o_core_n,
   input  logic [255:0] i_core_result,
   input  logic         i_core_finished
);

   localparam int unsigned      CNT_W       = $clog2(IN_BYTES);
   localparam logic [CNT_W-1:0] IN_LAST     = CNT_W'(IN_BYTES - 1);
   localparam logic [CNT_W-1:0] OUT_LAST    = CNT_W'(OUT_BYTES - 1);
   localparam logic [4:0]       ADDR_RX     = 5'(RX_BASE);
   localparam logic [4:0]       ADDR_TX     = 5'(TX_BASE);
   localparam logic [4:0]       ADDR_STATUS = 5'(STATUS_BASE);

   typedef enum logic [2:0] {StQueryRx, StReadRx, StCalc, StQueryTx, StWriteTx} state_e;
   typedef enum logic [1:0] {PhN, PhE, PhData} phase_e;

   state_e           r_state, w_state_nxt;
   phase_e           r_phase, w_phase_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_read, w_read_nxt;
   logic             r_write, w_write_nxt;
   logic [4:0]       r_addr, w_addr_nxt;
   logic [31:0]      r_wdata, w_wdata_nxt;
   logic             r_start, w_start_nxt;
   logic [255:0]     r_n, w_n_nxt;
   logic [255:0]     r_e, w_e_nxt;
   logic [255:0]     r_a, w_a_nxt;
   // Top result byte is never transmitted, so only 248 bits are kept.
   logic [247:0]     r_result, w_result_nxt;
   logic [7:0]       w_rx_byte;
   logic             w_unused;

   assign w_rx_byte = avm_readdata[7:0];
   assign w_unused  = ^{avm_readdata[31:8], i_core_result[255:248]};

   always_comb begin
      w_state_nxt  = r_state;
      w_phase_nxt  = r_phase;
      w_cnt_nxt    = r_cnt;
      w_read_nxt   = r_read;
      w_write_nxt  = r_write;
      w_addr_nxt   = r_addr;
      w_wdata_nxt  = r_wdata;
      w_start_nxt  = 1'b0;
      w_n_nxt      = r_n;
      w_e_nxt      = r_e;
      w_a_nxt      = r_a;
      w_result_nxt = r_result;
      case (r_state)
         StQueryRx: begin
            if (!r_read) begin
               w_read_nxt = 1'b1;
            end else if (!avm_waitrequest) begin
               w_read_nxt = 1'b0;
               if (avm_readdata[RX_OK_BIT]) begin
                  w_state_nxt = StReadRx;
                  w_addr_nxt  = ADDR_RX;
               end
            end
         end
         StReadRx: begin
            if (!r_read) begin
               w_read_nxt = 1'b1;
            end else if (!avm_waitrequest) begin
               w_read_nxt  = 1'b0;
               w_addr_nxt  = ADDR_STATUS;
               w_state_nxt = StQueryRx;
               case (r_phase)
                  PhN:     w_n_nxt = {r_n[247:0], w_rx_byte};
                  PhE:     w_e_nxt = {r_e[247:0], w_rx_byte};
                  default: w_a_nxt = {r_a[247:0], w_rx_byte};
               endcase
               if (r_cnt == IN_LAST) begin
                  w_cnt_nxt = '0;
                  case (r_phase)
                     PhN:     w_phase_nxt = PhE;
                     PhE:     w_phase_nxt = PhData;
                     default: begin
                        w_phase_nxt = PhData;
                        w_state_nxt = StCalc;
                        w_start_nxt = 1'b1;
                     end
                  endcase
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         StCalc: begin
            if (i_core_finished) begin
               w_result_nxt = i_core_result[247:0];
               w_state_nxt  = StQueryTx;
            end
         end
         StQueryTx: begin
            if (!r_read) begin
               w_read_nxt = 1'b1;
            end else if (!avm_waitrequest) begin
               w_read_nxt = 1'b0;
               if (avm_readdata[TX_OK_BIT]) begin
                  w_state_nxt = StWriteTx;
                  w_addr_nxt  = ADDR_TX;
                  w_wdata_nxt = {24'b0, r_result[247:240]};
               end
            end
         end
         StWriteTx: begin
            if (!r_write) begin
               w_write_nxt = 1'b1;
            end else if (!avm_waitrequest) begin
               w_write_nxt  = 1'b0;
               w_addr_nxt   = ADDR_STATUS;
               w_result_nxt = {r_result[239:0], 8'h00};
               if (r_cnt == OUT_LAST) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = StQueryRx;
               end else begin
                  w_cnt_nxt   = r_cnt + 1'b1;
                  w_state_nxt = StQueryTx;
               end
            end
         end
         default: w_state_nxt = StQueryRx;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= StQueryRx;
         r_phase  <= PhN;
         r_cnt    <= '0;
         r_read   <= 1'b0;
         r_write  <= 1'b0;
         r_addr   <= ADDR_STATUS;
         r_wdata  <= '0;
         r_start  <= 1'b0;
         r_n      <= '0;
         r_e      <= '0;
         r_a      <= '0;
         r_result <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_phase  <= w_phase_nxt;
         r_cnt    <= w_cnt_nxt;
         r_read   <= w_read_nxt;
         r_write  <= w_write_nxt;
         r_addr   <= w_addr_nxt;
         r_wdata  <= w_wdata_nxt;
         r_start  <= w_start_nxt;
         r_n      <= w_n_nxt;
         r_e      <= w_e_nxt;
         r_a      <= w_a_nxt;
         r_result <= w_result_nxt;
      end
   end

   assign avm_address   = r_addr;
   assign avm_read      = r_read;
   assign avm_write     = r_write;
   assign avm_writedata = r_wdata;
   assign o_core_start  = r_start;
   assign o_core_a      = r_a;
   assign o_core_e      = r_e;
   assign o_core_n      = r_n;

endmodule

// File: tb/tb_rsa256_uart_bridge.sv
// Bench for rsa256_uart_bridge: Avalon UART slave model with stalls and status gating, plus a
// behavioural modular-exponentiation core; table vectors, corner sequences and random blocks.
module tb_rsa256_uart_bridge;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [4:0]   avm_address;
   logic         avm_read, avm_write, o_core_start;
   logic [31:0]  avm_readdata = '0;
   logic [31:0]  avm_writedata;
   logic         avm_waitrequest = 1'b0;
   logic [255:0] o_core_a, o_core_e, o_core_n;
   logic [255:0] core_result = '0;
   logic         core_finished = 1'b0;

   rsa256_uart_bridge dut (
      .i_clk(clk), .i_rst(rst),
      .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
      .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
      .o_core_start(o_core_start), .o_core_a(o_core_a), .o_core_e(o_core_e),
      .o_core_n(o_core_n), .i_core_result(core_result), .i_core_finished(core_finished)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [255:0] a;
      logic [255:0] res;
      bit           spur;
   } vec_t;

   int checks = 0, failures = 0;
   logic [7:0] rx_q[$];
   logic [7:0] tx_log[$];
   int rx_reads = 0, starts = 0, proto_err = 0, core_err = 0;
   int rx_lowpolls = 0, tx_lowpolls = 0, rx_stall_cycles = 0;
   int rx_hold = 0, tx_hold = 0, tx_hold_cfg = 0, rx_stall_once = 0, rand_stall_max = 0;
   int stall_cnt = 0, tx_in_blk = 0, core_delay = 0;
   bit stalling = 0, pend_valid = 0, pend_rd = 0, pend_wr = 0;
   bit last_rx_ok = 0, last_tx_ok = 0, core_busy = 0, force_en = 0, spur_req = 0;
   logic [4:0] pend_addr, held_addr;
   logic held_rd, held_wr;
   logic [7:0] pend_byte;
   logic [255:0] cap_a, cap_e, cap_n, core_res, force_val;

   function automatic logic [255:0] modexp(input logic [255:0] b, input logic [255:0] e,
                                           input logic [255:0] m);
      logic [511:0] r, x, mm;
      mm = {256'b0, m};
      r  = 512'd1 % mm;
      x  = {256'b0, b} % mm;
      for (int i = 0; i < 256; i++) begin
         if (e[i]) r = (r * x) % mm;
         x = (x * x) % mm;
      end
      return r[255:0];
   endfunction

   function automatic logic [255:0] rnd256();
      logic [255:0] v = '0;
      for (int i = 0; i < 8; i++) v = {v[223:0], 32'($urandom)};
      return v;
   endfunction

   // UART slave, protocol monitor and core model, all evaluated away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         pend_valid = 0; stalling = 0; avm_waitrequest = 1'b0;
         core_busy = 0; core_finished = 1'b0; last_rx_ok = 0; last_tx_ok = 0;
      end else begin
         if (pend_valid) begin
            pend_valid = 0;
            if (pend_rd && pend_addr == 5'd0) begin
               if (rx_q.size() > 0) void'(rx_q.pop_front());
               rx_reads++;
            end
            if (pend_wr) begin
               tx_log.push_back(pend_byte);
               tx_in_blk++;
               if (tx_in_blk < 31) tx_hold = tx_hold_cfg;
            end
         end
         if (avm_read && avm_write) proto_err++;
         if (avm_read || avm_write) begin
            if (!stalling) begin
               stalling = 1; held_addr = avm_address; held_rd = avm_read; held_wr = avm_write;
               if (avm_read && avm_address == 5'd0 && rx_stall_once > 0) begin
                  stall_cnt = rx_stall_once; rx_stall_once = 0;
               end else begin
                  stall_cnt = int'($urandom_range(rand_stall_max, 0));
               end
            end else if (held_addr != avm_address || held_rd != avm_read ||
                         held_wr != avm_write) begin
               proto_err++;
            end
            if (stall_cnt > 0) begin
               stall_cnt--; avm_waitrequest = 1'b1; avm_readdata = $urandom;
               if (avm_read && avm_address == 5'd0) rx_stall_cycles++;
            end else begin
               stalling = 0; avm_waitrequest = 1'b0; pend_valid = 1;
               pend_rd = avm_read; pend_wr = avm_write; pend_addr = avm_address;
               pend_byte = avm_writedata[7:0];
               avm_readdata = $urandom;
               if (avm_write) begin
                  if (avm_address != 5'd1 || !last_tx_ok || avm_writedata[31:8] != 0)
                     proto_err++;
                  last_tx_ok = 0;
               end else if (avm_address == 5'd2) begin
                  last_rx_ok = (rx_q.size() > 0) && (rx_hold == 0);
                  if (rx_q.size() > 0 && rx_hold > 0) begin rx_hold--; rx_lowpolls++; end
                  last_tx_ok = (tx_hold == 0);
                  if (tx_hold > 0) begin tx_hold--; tx_lowpolls++; end
                  avm_readdata[7] = last_rx_ok;
                  avm_readdata[6] = last_tx_ok;
               end else if (avm_address == 5'd0) begin
                  if (!last_rx_ok || rx_q.size() == 0) proto_err++;
                  else avm_readdata[7:0] = rx_q[0];
                  last_rx_ok = 0;
               end else begin
                  proto_err++;
               end
            end
         end else begin
            stalling = 0; avm_waitrequest = 1'b0;
         end
         core_finished = 1'b0;
         if (o_core_start) begin
            starts++;
            if (core_busy) core_err++;
            core_busy = 1; cap_a = o_core_a; cap_e = o_core_e; cap_n = o_core_n;
            core_delay = int'($urandom_range(8, 2));
            core_res = force_en ? force_val : modexp(cap_a, cap_e, cap_n);
            tx_in_blk = 0; tx_hold = tx_hold_cfg;
         end else if (core_busy) begin
            if (o_core_a != cap_a || o_core_e != cap_e || o_core_n != cap_n) core_err++;
            if (core_delay == 0) begin
               core_finished = 1'b1; core_result = core_res; core_busy = 0;
            end else begin
               core_delay--;
            end
         end else if (spur_req) begin
            core_finished = 1'b1; core_result = rnd256(); spur_req = 0;
         end
      end
   end

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic push256(input logic [255:0] v);
      for (int k = 31; k >= 0; k--) rx_q.push_back(v[8*k +: 8]);
   endtask

   task automatic run_block(input string nm, input logic [255:0] n, input logic [255:0] e,
                            input logic [255:0] a, input logic [255:0] res, input bit with_key);
      int tx0, rx0, st0, pe0, ce0;
      logic [247:0] got;
      tx0 = tx_log.size(); rx0 = rx_reads; st0 = starts; pe0 = proto_err; ce0 = core_err;
      got = '0;
      if (with_key) begin push256(n); push256(e); end
      push256(a);
      for (int c = 0; c < 6000 && tx_log.size() < tx0 + 31; c++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      chk({nm, " tx count"}, 256'(tx_log.size() - tx0), 256'd31);
      for (int k = 0; k < 31; k++)
         if (tx0 + k < tx_log.size()) got = {got[239:0], tx_log[tx0 + k]};
      chk({nm, " tx bytes"}, {8'h00, got}, {8'h00, res[247:0]});
      chk({nm, " rx reads"}, 256'(rx_reads - rx0), with_key ? 256'd96 : 256'd32);
      chk({nm, " start pulses"}, 256'(starts - st0), 256'd1);
      chk({nm, " core operand a"}, cap_a, a);
      chk({nm, " core operand e"}, cap_e, e);
      chk({nm, " core operand n"}, cap_n, n);
      chk({nm, " bus protocol errors"}, 256'(proto_err - pe0), 256'd0);
      chk({nm, " operand stability errors"}, 256'(core_err - ce0), 256'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst = 1'b1;
      rx_q.delete(); rx_hold = 0; tx_hold = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, " read"}, 256'(avm_read), 256'd0);
      chk({nm, " write"}, 256'(avm_write), 256'd0);
      chk({nm, " address"}, 256'(avm_address), 256'd2);
      chk({nm, " writedata"}, 256'(avm_writedata), 256'd0);
      chk({nm, " start"}, 256'(o_core_start), 256'd0);
      chk({nm, " a"}, o_core_a, 256'd0);
      chk({nm, " e"}, o_core_e, 256'd0);
      chk({nm, " n"}, o_core_n, 256'd0);
   endtask

   initial begin
      vec_t tbl[6];
      logic [255:0] kn, ke, ka, rn, re, ra;
      int base;
      tbl[0] = '{a: 256'd5,   res: 256'd125, spur: 1'b0};
      tbl[1] = '{a: 256'd2,   res: 256'd8,   spur: 1'b1};
      tbl[2] = '{a: 256'd7,   res: 256'd90,  spur: 1'b0};
      tbl[3] = '{a: 256'd0,   res: 256'd0,   spur: 1'b1};
      tbl[4] = '{a: 256'd252, res: 256'd252, spur: 1'b0};
      tbl[5] = '{a: 256'd10,  res: 256'd241, spur: 1'b0};
      kn = 256'd253; ke = 256'd3;

      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         spur_req = tbl[i].spur;
         run_block($sformatf("vec%0d", i), kn, ke, tbl[i].a, tbl[i].res, i == 0);
      end

      // RX_OK held low for ten polls while data is waiting.
      base = rx_lowpolls;
      rx_hold = 10;
      run_block("rx_ok gating", kn, ke, 256'd4, 256'd64, 1'b0);
      chk("rx_ok low polls", 256'(rx_lowpolls - base), 256'd10);

      // Five-cycle waitrequest on the first RX data read.
      base = rx_stall_cycles;
      rx_stall_once = 5;
      run_block("rx stall", kn, ke, 256'd3, 256'd27, 1'b0);
      chk("rx stall cycles", 256'(rx_stall_cycles - base), 256'd5);

      // Forced result 00 01 .. 1F with TX_OK low for four polls before each byte.
      force_val = '0;
      for (int k = 0; k < 32; k++) force_val = {force_val[247:0], 8'(k)};
      force_en = 1; tx_hold_cfg = 4;
      base = tx_lowpolls;
      run_block("tx_ok gating", kn, ke, 256'd9, force_val, 1'b0);
      chk("tx_ok low polls", 256'(tx_lowpolls - base), 256'd124);
      force_en = 0; tx_hold_cfg = 0;

      // Random key and blocks with random bus stalls.
      do_reset();
      rand_stall_max = 3;
      rn = rnd256(); rn[255:248] = '0; rn[247] = 1'b1; rn[0] = 1'b1;
      re = rnd256();
      for (int i = 0; i < 3; i++) begin
         ra = rnd256() % rn;
         run_block($sformatf("rand%0d", i), rn, re, ra, modexp(ra, re, rn), i == 0);
      end

      // Reset in the middle of loading a fresh key.
      do_reset();
      base = rx_reads;
      push256(rnd256()); push256(rnd256()); push256(rnd256());
      for (int c = 0; c < 2000 && rx_reads < base + 40; c++) @(posedge clk);
      chk("bytes before mid-op reset", 256'(rx_reads - base >= 40), 256'd1);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 chk_reset_outputs("mid-op reset");
      rx_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      rn = rnd256(); rn[255:248] = '0; rn[200] = 1'b1; rn[0] = 1'b1;
      re = rnd256(); ka = rnd256() % rn;
      run_block("post-reset", rn, re, ka, modexp(ka, re, rn), 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
